mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-ported unified memory between instruction fetch (IF) and data access (DM).
// - One transaction in flight at a time; returns a read-data/ack pulse to the winning requester.
// - Drives per-requester stall signals so the fetch and memory stages hold while blocked.
// - Sits between fetch/memory stages and the memory macro; replaces their direct memory hookup.
// PARAMETERS
// - MEM_LAT     1  cycles from mem_req issue to mem_rdata valid; legal 1..7
// - STARVE_MAX  4  consecutive DM grants with IF pending before IF is forced through; legal 1..15
// PORTS
// - clk        in   1   rising-edge clock, single clock domain
// - rst        in   1   synchronous, active-high reset
// - if_req     in   1   fetch request; held with if_addr stable until if_gnt
// - if_addr    in   32  fetch address (word access)
// - if_gnt     out  1   fetch accepted this cycle
// - if_rvalid  out  1   one-cycle pulse; if_rdata valid
// - if_rdata   out  32  fetched instruction
// - dm_req     in   1   data request; held with dm_* stable until dm_gnt
// - dm_we      in   1   1 = store, 0 = load
// - dm_type    in   3   access size/sign code, forwarded unchanged
// - dm_addr    in   32  data address
// - dm_wdata   in   32  store data
// - dm_gnt     out  1   data request accepted this cycle
// - dm_rvalid  out  1   one-cycle pulse; load data valid / store complete
// - dm_rdata   out  32  load data; 0 for stores
// - mem_req    out  1   memory access strobe, one cycle per transaction
// - mem_we     out  1   memory write enable, valid only with mem_req
// - mem_type   out  3   dm_type for DM; 3'b010 (word) for IF
// - mem_addr   out  32  muxed address
// - mem_wdata  out  32  dm_wdata for DM; 0 for IF
// - mem_rdata  in   32  memory read data, valid MEM_LAT cycles after mem_req
// - stall_if   out  1   hold fetch stage
// - stall_mem  out  1   hold memory stage
// BEHAVIOUR
// - States: IDLE, WAIT. Registers: state, owner (IF/DM), cnt[2:0], starve[3:0], last_owner.
// - IDLE, no req: all gnt/mem_* low; stay IDLE.
// - IDLE, req present: pick winner; combinationally assert its gnt and mem_req with its fields;
//   next cycle state=WAIT, owner=winner, cnt=MEM_LAT-1.
// - WAIT: cnt decrements each cycle; at cnt==0 pulse owner's rvalid with mem_rdata (DM store: rdata=0),
//   state -> IDLE. No new grant in the completion cycle; min 2 cycles/access at MEM_LAT=1.
// - Priority (default): DM wins when both request. starve +1 on each DM grant while if_req=1;
//   starve reset on IF grant or when if_req=0. When starve==STARVE_MAX, IF wins next arbitration.
// - mem_we = owner-is-DM & dm_we & mem_req; IF never writes.
// - stall_if  = (if_req & ~if_gnt) | (state==WAIT & owner==IF & ~if_rvalid).
// - stall_mem = (dm_req & ~dm_gnt) | (state==WAIT & owner==DM & ~dm_rvalid).
// - rdata outputs hold last returned value between pulses; zero after reset.
// - Reset values: state=IDLE, cnt=0, starve=0, last_owner=DM, all outputs 0 (stalls follow reqs).
// - Reset mid-WAIT: transaction abandoned, no rvalid issued; memory side effects already issued stand.
// - Requester dropping req before gnt: no transaction; no error.
// - Simultaneous if_req/dm_req rising in same IDLE cycle: exactly one gnt, never both.
// CONFIGURATION
// - MEM_ARB_RR_EN defined: round-robin on conflict; winner = requester != last_owner;
//   last_owner updated on every grant; starve counter and STARVE_MAX unused.
// - MEM_ARB_RR_EN undefined: fixed DM priority with starvation guard as above.
// TESTING
// - IF only, if_addr=0x100, MEM_LAT=1 -> if_gnt+mem_req cycle 0, if_rvalid cycle 1, if_rdata=mem word.
// - Both req every cycle, default build, STARVE_MAX=4 -> grant order DM,DM,DM,DM,IF,DM,...
// - Both req, MEM_ARB_RR_EN, last_owner=DM after reset -> grants IF,DM,IF,DM alternating.
// - DM store dm_addr=0x40 dm_wdata=0xDEADBEEF -> mem_we=1 one cycle, dm_rvalid later, dm_rdata=0.
// - MEM_LAT=3, DM load -> dm_rvalid exactly 3 cycles after dm_gnt; stall_mem high until then.
// - rst asserted in WAIT -> next cycle IDLE, no rvalid, all outputs zero.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch/memory stages, the arbiter and the unified memory macro.
// The arbiter uses the slave view; requesters plus memory together form the master view.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        dm_req;
    logic        dm_we;
    logic [2:0]  dm_type;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_type;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        stall_if;
    logic        stall_mem;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_type, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output mem_req, mem_we, mem_type, mem_addr, mem_wdata, stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_type, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  mem_req, mem_we, mem_type, mem_addr, mem_wdata, stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access, one access in flight.
// Define MEM_ARB_RR_EN for round-robin conflict resolution; default is DM priority with IF starvation guard.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);

    // state  | meaning
    // S_IDLE | no access outstanding; a pending request is granted combinationally
    // S_WAIT | access issued, counting down to the read-data return cycle

    if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be 1..7");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
        $error("mem_port_arbiter: STARVE_MAX must be 1..15");
    end

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;
    typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_e;

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        store_q, store_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
`ifdef MEM_ARB_RR_EN
    owner_e      last_owner_q, last_owner_d;
`else
    logic [3:0]  starve_q, starve_d;
`endif

    logic if_wins;
    logic gnt_if, gnt_dm;
    logic rv_if, rv_dm;
    logic done;

    always_comb begin
`ifdef MEM_ARB_RR_EN
        if_wins = bus.if_req & (~bus.dm_req | (last_owner_q == OWN_DM));
`else
        if_wins = bus.if_req & (~bus.dm_req | (starve_q >= 4'(STARVE_MAX)));
`endif
        // Reset suppresses every handshake so an abandoned access never returns data.
        gnt_if = (state_q == S_IDLE) & if_wins & ~rst;
        gnt_dm = (state_q == S_IDLE) & bus.dm_req & ~if_wins & ~rst;
        done   = (state_q == S_WAIT) & (cnt_q == 3'd0);
        rv_if  = done & (owner_q == OWN_IF) & ~rst;
        rv_dm  = done & (owner_q == OWN_DM) & ~rst;
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        store_d    = store_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;

        if (gnt_if || gnt_dm) begin
            state_d = S_WAIT;
            owner_d = gnt_dm ? OWN_DM : OWN_IF;
            cnt_d   = LAT_M1;
            store_d = gnt_dm & bus.dm_we;
        end else if (state_q == S_WAIT) begin
            if (cnt_q == 3'd0) begin
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end

        if (rv_if) begin
            if_rdata_d = bus.mem_rdata;
        end
        if (rv_dm) begin
            dm_rdata_d = store_q ? 32'd0 : bus.mem_rdata;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_comb begin
        last_owner_d = last_owner_q;
        if (gnt_if) begin
            last_owner_d = OWN_IF;
        end else if (gnt_dm) begin
            last_owner_d = OWN_DM;
        end
    end
`else
    always_comb begin
        starve_d = starve_q;
        if (!bus.if_req || gnt_if) begin
            starve_d = 4'd0;
        end else if (gnt_dm && starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_DM;
            cnt_q        <= 3'd0;
            store_q      <= 1'b0;
            if_rdata_q   <= 32'd0;
            dm_rdata_q   <= 32'd0;
`ifdef MEM_ARB_RR_EN
            last_owner_q <= OWN_DM;
`else
            starve_q     <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            store_q      <= store_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_owner_q <= last_owner_d;
`else
            starve_q     <= starve_d;
`endif
        end
    end

    assign bus.if_gnt    = gnt_if;
    assign bus.dm_gnt    = gnt_dm;
    assign bus.mem_req   = gnt_if | gnt_dm;
    assign bus.mem_we    = gnt_dm & bus.dm_we;
    assign bus.mem_type  = gnt_dm ? bus.dm_type  : (gnt_if ? 3'b010 : 3'b000);
    assign bus.mem_addr  = gnt_dm ? bus.dm_addr  : (gnt_if ? bus.if_addr : 32'd0);
    assign bus.mem_wdata = gnt_dm ? bus.dm_wdata : 32'd0;

    assign bus.if_rvalid = rv_if;
    assign bus.dm_rvalid = rv_dm;
    assign bus.if_rdata  = rv_if ? bus.mem_rdata : if_rdata_q;
    assign bus.dm_rdata  = rv_dm ? (store_q ? 32'd0 : bus.mem_rdata) : dm_rdata_q;

    assign bus.stall_if  = (bus.if_req & ~gnt_if)
                         | ((state_q == S_WAIT) & (owner_q == OWN_IF) & ~rv_if);
    assign bus.stall_mem = (bus.dm_req & ~gnt_dm)
                         | ((state_q == S_WAIT) & (owner_q == OWN_DM) & ~rv_dm);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table-driven single accesses, grant-order sequence,
// MEM_LAT=3 latency and reset-while-waiting on a second instance.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic rst3;
    always #5 clk = ~clk;

    mem_port_arbiter_if b1 ();
    mem_port_arbiter_if b3 ();

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_dut  (.clk(clk), .rst(rst),  .bus(b1));
    mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (.clk(clk), .rst(rst3), .bus(b3));

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory models: read word appears MEM_LAT cycles after mem_req, junk otherwise.
    logic [31:0] rd1;
    logic [31:0] p3 [3];
    always @(posedge clk) begin
        rd1   <= b1.mem_req ? memf(b1.mem_addr) : 32'hBAD0_BAD0;
        p3[0] <= b3.mem_req ? memf(b3.mem_addr) : 32'hBAD0_BAD0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign b1.mem_rdata = rd1;
    assign b3.mem_rdata = p3[2];

    typedef struct {
        logic        src;
        logic [31:0] data;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic        ifr;
        logic [31:0] ia;
        logic        dmr;
        logic        we;
        logic [2:0]  ty;
        logic [31:0] da;
        logic [31:0] wd;
        logic        e_if;
        logic        e_dm;
        logic        e_we;
        logic [2:0]  e_ty;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
    } vec_t;
    vec_t vecs[6];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sb_sample();
        exp_t e;
        chk("both_rvalid", {31'd0, b1.if_rvalid & b1.dm_rvalid}, 32'd0);
        if (b1.if_rvalid || b1.dm_rvalid) begin
            chk("sb_nonempty", {31'd0, sbq.size() != 0}, 32'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("rv_src", {31'd0, b1.dm_rvalid}, {31'd0, e.src});
                chk("rv_data", b1.dm_rvalid ? b1.dm_rdata : b1.if_rdata, e.data);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        sb_sample();
    endtask

    task automatic drain();
        for (int n = 0; n < 8 && sbq.size() != 0; n++) step();
        chk("rvalid_timeout", sbq.size(), 32'd0);
        sbq.delete();
    endtask

    logic        ord[6];
    logic [31:0] last_if, last_dm;
    int          k, n;

    initial begin
        rst  = 1'b1;
        rst3 = 1'b1;
        b1.if_req = 0; b1.if_addr = 0; b1.dm_req = 0; b1.dm_we = 0;
        b1.dm_type = 0; b1.dm_addr = 0; b1.dm_wdata = 0;
        b3.if_req = 0; b3.if_addr = 0; b3.dm_req = 0; b3.dm_we = 0;
        b3.dm_type = 0; b3.dm_addr = 0; b3.dm_wdata = 0;

`ifdef MEM_ARB_RR_EN
        ord = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        ord = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`endif
        //           ifr ia            dmr we ty      da          wd            eif edm ewe ety     eaddr         ewd
        vecs[0] = '{1, 32'h100,       0, 0, 3'b000, 32'h0,      32'h0,        1, 0, 0, 3'b010, 32'h100,      32'h0};
        vecs[1] = '{0, 32'h0,         1, 0, 3'b001, 32'h200,    32'h1234,     0, 1, 0, 3'b001, 32'h200,      32'h1234};
        vecs[2] = '{0, 32'h0,         1, 1, 3'b010, 32'h40,     32'hDEADBEEF, 0, 1, 1, 3'b010, 32'h40,       32'hDEADBEEF};
`ifdef MEM_ARB_RR_EN
        vecs[3] = '{1, 32'h300,       1, 0, 3'b100, 32'h500,    32'h55,       1, 0, 0, 3'b010, 32'h300,      32'h0};
`else
        vecs[3] = '{1, 32'h300,       1, 0, 3'b100, 32'h500,    32'h55,       0, 1, 0, 3'b100, 32'h500,      32'h55};
`endif
        vecs[4] = '{1, 32'h600,       1, 1, 3'b001, 32'h700,    32'hCAFE,     0, 1, 1, 3'b001, 32'h700,      32'hCAFE};
        vecs[5] = '{1, 32'hFFFFFFFC,  0, 0, 3'b000, 32'h0,      32'h0,        1, 0, 0, 3'b010, 32'hFFFFFFFC, 32'h0};

        // Reset: grants suppressed, stalls follow requests.
        step();
        b1.if_req = 1; b1.dm_req = 1;
        #1;
        chk("rst_gnt", {30'd0, b1.if_gnt, b1.dm_gnt}, 32'd0);
        chk("rst_mem_req", {31'd0, b1.mem_req}, 32'd0);
        chk("rst_stalls", {30'd0, b1.stall_if, b1.stall_mem}, 32'd3);
        b1.if_req = 0; b1.dm_req = 0;
        step();
        rst = 1'b0;
        rst3 = 1'b0;
        #1;
        chk("rst_ctl", {26'd0, b1.if_gnt, b1.dm_gnt, b1.if_rvalid, b1.dm_rvalid, b1.mem_req, b1.mem_we}, 32'd0);
        chk("rst_rdata", b1.if_rdata | b1.dm_rdata, 32'd0);
        chk("rst_stall", {30'd0, b1.stall_if, b1.stall_mem}, 32'd0);
        last_if = 32'd0;
        last_dm = 32'd0;

        foreach (vecs[i]) begin
            b1.if_req = vecs[i].ifr; b1.if_addr = vecs[i].ia;
            b1.dm_req = vecs[i].dmr; b1.dm_we = vecs[i].we; b1.dm_type = vecs[i].ty;
            b1.dm_addr = vecs[i].da; b1.dm_wdata = vecs[i].wd;
            #1;
            chk("gnt", {30'd0, b1.if_gnt, b1.dm_gnt}, {30'd0, vecs[i].e_if, vecs[i].e_dm});
            chk("mem_req", {31'd0, b1.mem_req}, 32'd1);
            chk("mem_we", {31'd0, b1.mem_we}, {31'd0, vecs[i].e_we});
            chk("mem_type", {29'd0, b1.mem_type}, {29'd0, vecs[i].e_ty});
            chk("mem_addr", b1.mem_addr, vecs[i].e_addr);
            chk("mem_wdata", b1.mem_wdata, vecs[i].e_wd);
            chk("stall_grant", {30'd0, b1.stall_if, b1.stall_mem},
                {30'd0, vecs[i].ifr & ~vecs[i].e_if, vecs[i].dmr & ~vecs[i].e_dm});
            if (vecs[i].e_dm) begin
                last_dm = vecs[i].we ? 32'd0 : memf(vecs[i].da);
                sbq.push_back('{1'b1, last_dm});
            end else begin
                last_if = memf(vecs[i].ia);
                sbq.push_back('{1'b0, last_if});
            end
            step();
            chk("rvalid_lat1", {31'd0, b1.if_rvalid | b1.dm_rvalid}, 32'd1);
            chk("no_gnt_done", {29'd0, b1.if_gnt, b1.dm_gnt, b1.mem_req}, 32'd0);
            b1.if_req = 0; b1.dm_req = 0;
            drain();
            step();
            chk("rdata_hold_if", b1.if_rdata, last_if);
            chk("rdata_hold_dm", b1.dm_rdata, last_dm);
            chk("rvalid_idle", {30'd0, b1.if_rvalid, b1.dm_rvalid}, 32'd0);
        end

        // Both requesting every cycle from a fresh reset: grant order.
        rst = 1'b1;
        step();
        rst = 1'b0;
        b1.if_req = 1; b1.if_addr = 32'h1000;
        b1.dm_req = 1; b1.dm_we = 0; b1.dm_type = 3'b010; b1.dm_addr = 32'h2000;
        k = 0;
        for (int c = 0; c < 40 && k < 6; c++) begin
            #1;
            chk("one_gnt", {31'd0, b1.if_gnt & b1.dm_gnt}, 32'd0);
            if (b1.if_gnt || b1.dm_gnt) begin
                chk("grant_order", {31'd0, b1.dm_gnt}, {31'd0, ord[k]});
                chk("stall_if_order", {31'd0, b1.stall_if}, {31'd0, ord[k]});
                sbq.push_back('{ord[k], ord[k] ? memf(32'h2000) : memf(32'h1000)});
                k++;
            end
            step();
        end
        chk("order_count", k, 32'd6);
        b1.if_req = 0; b1.dm_req = 0;
        drain();

        // MEM_LAT=3 load: rvalid exactly 3 cycles after grant, stall_mem held meanwhile.
        b3.dm_req = 1; b3.dm_we = 0; b3.dm_type = 3'b010; b3.dm_addr = 32'h80;
        #1;
        chk("lat3_gnt", {31'd0, b3.dm_gnt}, 32'd1);
        step();
        b3.dm_req = 0;
        n = 1;
        while (!b3.dm_rvalid && n < 10) begin
            chk("lat3_stall_mem", {31'd0, b3.stall_mem}, 32'd1);
            step();
            n++;
        end
        chk("lat3_cycles", n, 32'd3);
        chk("lat3_rdata", b3.dm_rdata, memf(32'h80));
        chk("lat3_stall_done", {31'd0, b3.stall_mem}, 32'd0);
        step();

        // Reset while waiting: access abandoned, no rvalid, outputs cleared.
        b3.dm_req = 1; b3.dm_addr = 32'h90;
        #1;
        chk("rstw_gnt", {31'd0, b3.dm_gnt}, 32'd1);
        step();
        b3.dm_req = 0;
        rst3 = 1'b1;
        #1;
        chk("rstw_no_rvalid0", {31'd0, b3.dm_rvalid}, 32'd0);
        step();
        rst3 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("rstw_ctl", {24'd0, b3.if_gnt, b3.dm_gnt, b3.if_rvalid, b3.dm_rvalid,
                             b3.mem_req, b3.mem_we, b3.stall_if, b3.stall_mem}, 32'd0);
            chk("rstw_rdata", b3.dm_rdata | b3.if_rdata, 32'd0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
